scsi_target_seq: RTL

Simulated SCSI-1 disk target: the responder side of the bus driven by the NCR5380-style initiator in the Mac core. Answers selection on its ID, collects the CDB, and moves 512-byte sectors between the bus and an internal sector buffer. The buffer is filled and drained by the MiSTer io controller (io_rd/io_wr/io_ack, sd_buff_*). Runs the full phase sequence COMMAND -> DATA IN/OUT -> STATUS -> MESSAGE IN, then releases BSY.

---
 rtl/scsi_target_seq.sv | 338 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/scsi_target_seq.sv
// rtl/scsi_target_seq.sv - SCSI-1 disk target sequencer with 512-byte sector buffer
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   rst                            SCSI bus reset, sampled on clk
//   sel, atn, ack, din             initiator-driven bus lines (atn unused)
//   bsy, msg, cd, io, req, dout    target-driven bus lines
//   io_lba, io_rd, io_wr, io_ack   sector transfer requests to the io controller
//   sd_buff_addr/dout/din/wr       io-side port of the sector buffer
module scsi_target_seq #(
  parameter int ID = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rst,
  input  logic        sel,
  input  logic        atn,
  input  logic        ack,
  input  logic [7:0]  din,
  output logic        bsy,
  output logic        msg,
  output logic        cd,
  output logic        io,
  output logic        req,
  output logic [7:0]  dout,
  output logic [31:0] io_lba,
  output logic        io_rd,
  output logic        io_wr,
  input  logic        io_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  output logic [7:0]  sd_buff_din,
  input  logic        sd_buff_wr
);

  typedef enum logic [3:0] {
    S_IDLE, S_SELECTED, S_CMD, S_DECODE, S_RD_REQ,
    S_DATA_IN, S_DATA_OUT, S_WR_REQ, S_STATUS, S_MSGIN
  } state_t;

  localparam logic [2:0] PH_DOUT = 3'b000;
  localparam logic [2:0] PH_DIN  = 3'b001;
  localparam logic [2:0] PH_CMD  = 3'b010;
  localparam logic [2:0] PH_STAT = 3'b011;
  localparam logic [2:0] PH_MSGI = 3'b111;

  state_t      state_q, state_d;
  logic        bsy_q, bsy_d, req_q, req_d, io_rd_q, io_rd_d, io_wr_q, io_wr_d;
  logic [2:0]  ph_q, ph_d;
  logic [7:0]  dout_q, dout_d;
  logic [31:0] io_lba_q, io_lba_d, lba_q, lba_d;
  logic [15:0] count_q, count_d;
  logic [8:0]  bidx_q, bidx_d;
  logic [3:0]  n_q, n_d;
  logic [7:0]  cdb_q [10];
  logic [7:0]  cdb_d [10];
  logic        hs_q, hs_d;        // ack seen high, waiting for it to fall
  logic        io_done_q, io_done_d;
  logic [1:0]  dly_q, dly_d;      // settle time before req may rise
  logic [1:0]  ack_s_q, ack_s_d;  // [0] newest registered ack, [1] previous

  logic [7:0]  buf_mem [512];
  logic [7:0]  bus_rd_q, sd_buff_din_q;
  logic        bus_we;

  logic        ack_rise, hs_rise, hs_fall, can_raise, go_status;
  logic [7:0]  st_byte;
  logic [3:0]  cdb_len;

  wire unused_ok = atn ^ (^cdb_q[1][7:5]) ^ (^cdb_q[6]) ^ (^cdb_q[9]) ^ (^cdb_q[5]);

  assign ack_rise  = ack_s_q[0] & ~ack_s_q[1];
  assign hs_rise   = req_q & ack_rise;
  assign hs_fall   = hs_q & ~ack_s_q[0];
  // A new req needs settled data and ack observed low first.
  assign can_raise = ~req_q & ~hs_q & (dly_q == 2'd0) & ~ack_s_q[0];
  assign cdb_len   = (cdb_q[0][7:5] == 3'd1) ? 4'd10 : 4'd6;

  always_comb begin
    state_d   = state_q;
    bsy_d     = bsy_q;
    req_d     = req_q;
    io_rd_d   = io_rd_q;
    io_wr_d   = io_wr_q;
    ph_d      = ph_q;
    dout_d    = dout_q;
    io_lba_d  = io_lba_q;
    lba_d     = lba_q;
    count_d   = count_q;
    bidx_d    = bidx_q;
    n_d       = n_q;
    cdb_d     = cdb_q;
    hs_d      = hs_q;
    io_done_d = io_done_q;
    dly_d     = (dly_q != 2'd0) ? dly_q - 2'd1 : 2'd0;
    ack_s_d   = {ack_s_q[0], ack};
    bus_we    = 1'b0;
    go_status = 1'b0;
    st_byte   = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (sel && din[ID] && !bsy_q) begin
          bsy_d   = 1'b1;
          state_d = S_SELECTED;
        end
      end
      S_SELECTED: begin
        if (!sel) begin
          state_d = S_CMD;
          n_d     = 4'd0;
          ph_d    = PH_CMD;
          hs_d    = 1'b0;
          dly_d   = 2'd3;
        end
      end
      S_CMD: begin
        if (hs_rise) begin
          cdb_d[n_q] = din;
          req_d      = 1'b0;
          hs_d       = 1'b1;
        end else if (hs_fall) begin
          hs_d  = 1'b0;
          dly_d = 2'd3;
          if (n_q == cdb_len - 4'd1) state_d = S_DECODE;
          else n_d = n_q + 4'd1;
        end else if (can_raise) begin
          req_d = 1'b1;
        end
      end
      S_DECODE: begin
        bidx_d    = 9'd0;
        io_done_d = 1'b0;
        dly_d     = 2'd3;
        case (cdb_q[0])
          8'h00: go_status = 1'b1;
          8'h08, 8'h0A: begin
            lba_d   = {11'b0, cdb_q[1][4:0], cdb_q[2], cdb_q[3]};
            count_d = (cdb_q[4] == 8'h00) ? 16'd256 : {8'h00, cdb_q[4]};
            if (cdb_q[0] == 8'h08) begin
              state_d = S_RD_REQ;
            end else begin
              state_d = S_DATA_OUT;
              ph_d    = PH_DOUT;
            end
          end
          8'h28, 8'h2A: begin
            lba_d   = {cdb_q[2], cdb_q[3], cdb_q[4], cdb_q[5]};
            count_d = {cdb_q[7], cdb_q[8]};
            if ({cdb_q[7], cdb_q[8]} == 16'd0) begin
              go_status = 1'b1;
            end else if (cdb_q[0] == 8'h28) begin
              state_d = S_RD_REQ;
            end else begin
              state_d = S_DATA_OUT;
              ph_d    = PH_DOUT;
            end
          end
          default: begin
            go_status = 1'b1;
            st_byte   = 8'h02;
          end
        endcase
      end
      S_RD_REQ: begin
        io_lba_d = lba_q;
        if (!io_done_q) begin
          io_rd_d = 1'b1;
          if (io_rd_q && io_ack) begin
            io_rd_d   = 1'b0;
            io_done_d = 1'b1;
          end
        end else if (!io_ack) begin
          io_done_d = 1'b0;
          state_d   = S_DATA_IN;
          ph_d      = PH_DIN;
          bidx_d    = 9'd0;
          hs_d      = 1'b0;
          dly_d     = 2'd3;
        end
      end
      S_DATA_IN: begin
        // Buffer read is registered, then dout is registered: two cycles
        // after bidx moves, which the settle counter covers.
        dout_d = bus_rd_q;
        if (hs_rise) begin
          req_d = 1'b0;
          hs_d  = 1'b1;
        end else if (hs_fall) begin
          hs_d   = 1'b0;
          dly_d  = 2'd3;
          bidx_d = bidx_q + 9'd1;
          if (bidx_q == 9'd511) begin
            lba_d   = lba_q + 32'd1;
            count_d = count_q - 16'd1;
            if (count_q == 16'd1) go_status = 1'b1;
            else state_d = S_RD_REQ;
          end
        end else if (can_raise) begin
          req_d = 1'b1;
        end
      end
      S_DATA_OUT: begin
        if (hs_rise) begin
          bus_we = 1'b1;
          req_d  = 1'b0;
          hs_d   = 1'b1;
        end else if (hs_fall) begin
          hs_d   = 1'b0;
          dly_d  = 2'd3;
          bidx_d = bidx_q + 9'd1;
          if (bidx_q == 9'd511) begin
            state_d   = S_WR_REQ;
            io_done_d = 1'b0;
          end
        end else if (can_raise) begin
          req_d = 1'b1;
        end
      end
      S_WR_REQ: begin
        io_lba_d = lba_q;
        if (!io_done_q) begin
          io_wr_d = 1'b1;
          if (io_wr_q && io_ack) begin
            io_wr_d   = 1'b0;
            io_done_d = 1'b1;
          end
        end else if (!io_ack) begin
          io_done_d = 1'b0;
          lba_d     = lba_q + 32'd1;
          count_d   = count_q - 16'd1;
          dly_d     = 2'd3;
          if (count_q == 16'd1) go_status = 1'b1;
          else state_d = S_DATA_OUT;
        end
      end
      S_STATUS, S_MSGIN: begin
        if (hs_rise) begin
          req_d = 1'b0;
          hs_d  = 1'b1;
        end else if (hs_fall) begin
          hs_d   = 1'b0;
          dly_d  = 2'd3;
          dout_d = 8'h00;
          if (state_q == S_STATUS) begin
            state_d = S_MSGIN;
            ph_d    = PH_MSGI;
          end else begin
            state_d = S_IDLE;
            ph_d    = 3'b000;
            bsy_d   = 1'b0;
          end
        end else if (can_raise) begin
          req_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (go_status) begin
      state_d = S_STATUS;
      ph_d    = PH_STAT;
      dout_d  = st_byte;
      dly_d   = 2'd3;
    end

    if (rst) begin
      state_d   = S_IDLE;
      bsy_d     = 1'b0;
      req_d     = 1'b0;
      io_rd_d   = 1'b0;
      io_wr_d   = 1'b0;
      ph_d      = 3'b000;
      dout_d    = 8'h00;
      io_lba_d  = 32'd0;
      hs_d      = 1'b0;
      io_done_d = 1'b0;
      bus_we    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      bsy_q     <= 1'b0;
      req_q     <= 1'b0;
      io_rd_q   <= 1'b0;
      io_wr_q   <= 1'b0;
      ph_q      <= 3'b000;
      dout_q    <= 8'h00;
      io_lba_q  <= 32'd0;
      lba_q     <= 32'd0;
      count_q   <= 16'd0;
      bidx_q    <= 9'd0;
      n_q       <= 4'd0;
      hs_q      <= 1'b0;
      io_done_q <= 1'b0;
      dly_q     <= 2'd0;
      ack_s_q   <= 2'b00;
      for (int i = 0; i < 10; i++) cdb_q[i] <= 8'h00;
    end else begin
      state_q   <= state_d;
      bsy_q     <= bsy_d;
      req_q     <= req_d;
      io_rd_q   <= io_rd_d;
      io_wr_q   <= io_wr_d;
      ph_q      <= ph_d;
      dout_q    <= dout_d;
      io_lba_q  <= io_lba_d;
      lba_q     <= lba_d;
      count_q   <= count_d;
      bidx_q    <= bidx_d;
      n_q       <= n_d;
      hs_q      <= hs_d;
      io_done_q <= io_done_d;
      dly_q     <= dly_d;
      ack_s_q   <= ack_s_d;
      cdb_q     <= cdb_d;
    end
  end

  // Sector buffer: contents survive reset.
  always_ff @(posedge clk) begin
    if (sd_buff_wr) buf_mem[sd_buff_addr] <= sd_buff_dout;
    if (bus_we) buf_mem[bidx_q] <= din;
    sd_buff_din_q <= buf_mem[sd_buff_addr];
    bus_rd_q      <= buf_mem[bidx_q];
  end

  assign bsy         = bsy_q;
  assign {msg, cd, io} = ph_q;
  assign req         = req_q;
  assign dout        = dout_q;
  assign io_lba      = io_lba_q;
  assign io_rd       = io_rd_q;
  assign io_wr       = io_wr_q;
  assign sd_buff_din = sd_buff_din_q;

endmodule
